simplebus_master: RTL and testbench

Initiator for the SimpleBus register interface. It accepts read and write requests from a local valid/ready request port and buffers them in a small FIFO. It issues each request on the bus as a single-cycle command and captures read data after a fixed responder latency. Read data returns on a valid/ready response port. It sits between a local controller (sequencer, CPU shim or config engine) and any SimpleBus responder, such as the packet-path invert-control block.

---
 rtl/simplebus_pkg.sv | 26 ++
 rtl/simplebus_req_fifo.sv | 47 ++++
 rtl/simplebus_master.sv | 154 +++++++++++++++
 tb/tb_simplebus_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// SimpleBus shared types: op codes, master FSM states,
// default widths and the request record.
package simplebus_pkg;

  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;

  typedef enum logic {
    SB_READ  = 1'b0,
    SB_WRITE = 1'b1
  } sb_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RSP
  } sb_state_e;

  typedef struct packed {
    sb_op_e                op;
    logic [SB_ADDR_W-1:0]  addr;
    logic [SB_DATA_W-1:0]  wdata;
  } sb_req_t;

endpackage

// File: rtl/simplebus_req_fifo.sv
// Request FIFO for the SimpleBus master.
// Pointers carry an extra wrap bit to tell full from empty.
module simplebus_req_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/simplebus_master.sv
// SimpleBus initiator: FIFO-buffered requests, one command per issue.
// SIMPLEBUS_MASTER_WR_ACK_EN adds a response for every write.
module simplebus_master
  import simplebus_pkg::*;
#(
  parameter int ADDR_W     = SB_ADDR_W,
  parameter int DATA_W     = SB_DATA_W,
  parameter int REQ_DEPTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_cmd_valid,
  output logic              bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic              busy
);

  localparam int RW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t      head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      do_issue;
  sb_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic      cmd_n;
  logic      bus_op_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wr_data_n;
  logic      rsp_valid_n;
  logic      rsp_op_n;
  logic [DATA_W-1:0] rsp_rdata_n;

  simplebus_req_fifo #(
    .W     (RW),
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid && !full),
    .push_data ({req_op, req_addr, req_wdata}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign req_ready = !full;
  assign busy      = !empty || (state != IDLE);

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    do_issue      = 1'b0;
    pop           = 1'b0;
    cmd_n         = 1'b0;
    bus_op_n      = bus_op;
    bus_addr_n    = bus_addr;
    bus_wr_data_n = bus_wr_data;
    rsp_valid_n   = rsp_valid;
    rsp_op_n      = rsp_op;
    rsp_rdata_n   = rsp_rdata;
    unique case (state)
      IDLE: do_issue = !empty;
      CMD: begin
        if (bus_op == SB_WRITE) begin
`ifdef SIMPLEBUS_MASTER_WR_ACK_EN
          rsp_valid_n = 1'b1;
          rsp_op_n    = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RSP;
`else
          state_n  = IDLE;
          do_issue = !empty;
`endif
        end else begin
          cnt_n   = CW'(RD_LATENCY);
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          rsp_valid_n = 1'b1;
          rsp_op_n    = 1'b0;
          rsp_rdata_n = bus_rd_data;
          state_n     = RSP;
        end
      end
      RSP: begin
        // handshake edge may issue the next request directly
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
          do_issue    = !empty;
        end
      end
      default: state_n = IDLE;
    endcase
    if (do_issue) begin
      pop           = 1'b1;
      cmd_n         = 1'b1;
      bus_op_n      = head.op;
      bus_addr_n    = head.addr;
      bus_wr_data_n = head.wdata;
      state_n       = CMD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus_cmd_valid <= 1'b0;
      bus_op        <= 1'b0;
      bus_addr      <= '0;
      bus_wr_data   <= '0;
      rsp_valid     <= 1'b0;
      rsp_op        <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus_cmd_valid <= cmd_n;
      bus_op        <= bus_op_n;
      bus_addr      <= bus_addr_n;
      bus_wr_data   <= bus_wr_data_n;
      rsp_valid     <= rsp_valid_n;
      rsp_op        <= rsp_op_n;
      rsp_rdata     <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_simplebus_master.sv
// Bench for simplebus_master: directed steps, command and
// response scoreboards, and a simple RD_LATENCY=1 responder.
module tb_simplebus_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_op;
  logic [15:0] rsp_rdata;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_cmd    = 0;
  int run      = 0;
  int run_max  = 0;
  int n_snap;
  logic prev_rd = 1'b0;

  logic [32:0] cmdq [$];
  logic [16:0] rspq [$];
  logic [32:0] exp_cmd;
  logic [16:0] exp_rsp;

  logic [15:0] rmem [256] = '{default: 16'h0};
  logic [15:0] mmem [256] = '{default: 16'h0};
  logic [15:0] rd_q = 16'h0;

  simplebus_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_rdata     (rsp_rdata),
    .bus_cmd_valid (bus_cmd_valid),
    .bus_op        (bus_op),
    .bus_addr      (bus_addr),
    .bus_wr_data   (bus_wr_data),
    .bus_rd_data   (bus_rd_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder: read data valid the cycle after the command cycle
  always @(posedge clk) begin
    if (bus_cmd_valid && bus_op)
      rmem[bus_addr[7:0]] <= bus_wr_data;
    if (bus_cmd_valid && !bus_op)
      rd_q <= rmem[bus_addr[7:0]];
  end
  assign bus_rd_data = rd_q;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0;
      run     = 0;
    end else begin
      if (bus_cmd_valid) begin
        chk("rd_back_to_back", prev_rd, 0);
        n_cmd++;
        run++;
        if (run > run_max) run_max = run;
        chk("cmd_expected", cmdq.size() != 0, 1);
        if (cmdq.size() != 0) begin
          exp_cmd = cmdq.pop_front();
          chk("cmd", {bus_op, bus_addr, bus_wr_data}, exp_cmd);
        end
      end else begin
        run = 0;
      end
      prev_rd = bus_cmd_valid && !bus_op;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", rspq.size() != 0, 1);
        if (rspq.size() != 0) begin
          exp_rsp = rspq.pop_front();
          chk("rsp", {rsp_op, rsp_rdata}, exp_rsp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic op,
                      input logic [15:0] a,
                      input logic [15:0] d);
    int k = 0;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", k < 100, 1);
    @(posedge clk);
    cmdq.push_back({op, a, d});
    if (op) begin
      mmem[a[7:0]] = d;
`ifdef SIMPLEBUS_MASTER_WR_ACK_EN
      rspq.push_back({1'b1, 16'h0000});
`endif
    end else begin
      rspq.push_back({1'b0, mmem[a[7:0]]});
    end
    #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((cmdq.size() != 0 || rspq.size() != 0 || busy) && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", k < 200, 1);
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_op"}, rsp_op, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_cmd_valid"}, bus_cmd_valid, 0);
    chk({tag, "_bus_op"}, bus_op, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wr_data"}, bus_wr_data, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    rsp_ready = 1'b1;
    step(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // single write: one strobe, fields held afterwards
    push(1'b1, 16'h0009, 16'h0001);
    step(1);
    chk("wr_cmd_valid", bus_cmd_valid, 1);
    chk("wr_cmd_fields", {bus_op, bus_addr, bus_wr_data},
        {1'b1, 16'h0009, 16'h0001});
    step(1);
    chk("wr_cmd_pulse", bus_cmd_valid, 0);
    chk("wr_addr_hold", bus_addr, 16'h0009);
`ifdef SIMPLEBUS_MASTER_WR_ACK_EN
    chk("wr_ack", {rsp_valid, rsp_op, rsp_rdata}, {1'b1, 1'b1, 16'h0});
`else
    chk("wr_no_rsp", rsp_valid, 0);
`endif
    drain();

    // single read: response two edges after the command edge
    push(1'b0, 16'h0009, 16'h0000);
    step(1);
    chk("rd_cmd_valid", bus_cmd_valid, 1);
    step(1);
    chk("rd_rsp_early", rsp_valid, 0);
    step(1);
    chk("rd_rsp", {rsp_valid, rsp_op, rsp_rdata}, {1'b1, 1'b0, 16'h0001});
    drain();

    // stall in RSP, fill the FIFO, then release
    rsp_ready = 1'b0;
    push(1'b0, 16'h0009, 16'h0000);
    step(3);
    chk("stall_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 4; i++)
      push(1'b1, 16'h0010 + 16'(i), 16'h00A0 + 16'(i));
    chk("full_req_ready", req_ready, 0);
    n_snap = n_cmd;
    step(5);
    chk("stall_rdata", rsp_rdata, 16'h0001);
    chk("stall_rsp_held", rsp_valid, 1);
    chk("stall_busy", busy, 1);
    chk("stall_no_cmd", n_cmd, n_snap);
    rsp_ready = 1'b1;
    run_max   = 0;
    push(1'b1, 16'h0014, 16'h00A4);
    drain();
`ifndef SIMPLEBUS_MASTER_WR_ACK_EN
    chk("wr_stream_run", run_max >= 4, 1);
`endif

    // reset while a read sits in WAIT with a write queued behind it
    push(1'b0, 16'h0010, 16'h0000);
    push(1'b1, 16'h0020, 16'h0055);
    step(1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cmdq.delete();
    rspq.delete();
    mmem[8'h20] = 16'h0000;
    n_snap = n_cmd;
    #3;
    rst_n = 1'b1;
    step(3);
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_no_cmd", n_cmd, n_snap);
    chk("post_rst_empty", busy, 0);
    push(1'b0, 16'h0010, 16'h0000);
    step(3);
    chk("fresh_rd", {rsp_valid, rsp_rdata}, {1'b1, 16'h00A0});
    drain();
    push(1'b0, 16'h0020, 16'h0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
